// File: rtl/vout_tg_pkg.sv
// Shared definitions for the display timing generator: the blanking colour,
// the 1280x720@60 power-up timing, and the colour-bar lookup used by the
// optional test pattern (VOUT_TG_PATTERN_EN).
package vout_tg_pkg;

    // Black in BT.601 limited-range YCbCr; driven whenever de is low.
    localparam logic [23:0] BLANK_YCBCR = 24'h108080;

    // Bit positions of the sync bundle carried through the delay line.
    localparam int SYNC_W  = 3;
    localparam int SYNC_HS = 2;
    localparam int SYNC_VS = 1;
    localparam int SYNC_DE = 0;

    // 1280x720@60 timing, used until a legal configuration is captured.
    localparam int DEF_H_TOTAL  = 1650;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_V_TOTAL  = 750;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;
    localparam int DEF_V_ACTIVE = 720;

    // Eight 100% BT.601 colour bars, left to right: white .. black.
    function automatic logic [23:0] bar_ycbcr(input logic [2:0] idx);
        logic [23:0] val;
        case (idx)
            3'd0:    val = 24'hEB8080;  // white
            3'd1:    val = 24'hD21092;  // yellow
            3'd2:    val = 24'hAAA610;  // cyan
            3'd3:    val = 24'h913622;  // green
            3'd4:    val = 24'h6ACADE;  // magenta
            3'd5:    val = 24'h515AF0;  // red
            3'd6:    val = 24'h29F06E;  // blue
            default: val = 24'h108080;  // black
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vout_tg_delay.sv
// Fixed-depth shift register with synchronous clear. dout is the last
// stage; tap is the value that the last stage will load on the next edge,
// so a register fed from tap lines up with dout.
module vout_tg_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         pixel_clk,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [W-1:0] tap
);

    logic [W-1:0] stage_reg [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage samples the undelayed input.
                always_ff @(posedge pixel_clk) begin
                    if (clr) stage_reg[gi] <= '0;
                    else     stage_reg[gi] <= din;
                end
            end else begin : g_next
                // Later stages shift from the previous one.
                always_ff @(posedge pixel_clk) begin
                    if (clr) stage_reg[gi] <= '0;
                    else     stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end

        if (DEPTH == 1) begin : g_tap_in
            assign tap = din;
        end else begin : g_tap_stage
            assign tap = stage_reg[DEPTH-2];
        end
    endgenerate

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/vout_timing_gen.sv
// Display timing generator. Free-running h/v counters drive the raw vsync
// and the pixel FIFO read request; hs/vs/de are delayed by DATA_LATENCY so
// the registered pixel output lines up with the sync outputs.
// Optional: define VOUT_TG_PATTERN_EN to add an 8-bar colour pattern
// selected by pattern_sel; otherwise pattern_sel is ignored.
import vout_tg_pkg::*;

module vout_timing_gen #(
    parameter int DATA_LATENCY = 2,
    parameter int CNT_W        = 12
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] h_total,
    input  logic [CNT_W-1:0] h_sync,
    input  logic [CNT_W-1:0] h_bp,
    input  logic [CNT_W-1:0] h_active,
    input  logic [CNT_W-1:0] v_total,
    input  logic [CNT_W-1:0] v_sync,
    input  logic [CNT_W-1:0] v_bp,
    input  logic [CNT_W-1:0] v_active,
    input  logic             hs_pol,
    input  logic             vs_pol,
    input  logic             pattern_sel,
    output logic             vs_raw,
    output logic             pixel_rd_req,
    input  logic [23:0]      pixel_ycbcr_i,
    output logic             hs_o,
    output logic             vs_o,
    output logic             de_o,
    output logic [23:0]      pixel_ycbcr_o
);

    // Sums of three CNT_W fields need two extra bits to avoid overflow.
    localparam int SW = CNT_W + 2;

    logic [CNT_W-1:0] h_total_s_reg, h_sync_s_reg, h_bp_s_reg, h_active_s_reg;
    logic [CNT_W-1:0] v_total_s_reg, v_sync_s_reg, v_bp_s_reg, v_active_s_reg;
    logic [CNT_W-1:0] h_cnt_reg, v_cnt_reg;
    logic             run_reg;

    logic             cfg_legal, load_in, load_def;
    logic             h_last, v_last, frame_end;
    logic [SW-1:0]    h_act_start, h_act_end, v_act_start, v_act_end;
    logic             hs_raw, h_act, v_act;
    logic             clr;
    logic [SYNC_W-1:0] sync_raw, sync_dly, sync_tap;
    logic [23:0]      pixel_next;

    // Legality of the live configuration inputs.
    always_comb begin
        cfg_legal = (SW'(h_total) >= SW'(h_sync) + SW'(h_bp) + SW'(h_active))
                 && (SW'(v_total) >= SW'(v_sync) + SW'(v_bp) + SW'(v_active))
                 && (h_total >= CNT_W'(2))
                 && (v_total >= CNT_W'(2));
    end

    assign h_last    = (h_cnt_reg == h_total_s_reg - CNT_W'(1));
    assign v_last    = (v_cnt_reg == v_total_s_reg - CNT_W'(1));
    assign frame_end = run_reg && h_last && v_last;

    // Capture while in reset / on the release edge, and on the last pixel of
    // every frame; an illegal request keeps the old shadow, and an illegal
    // request during reset falls back to the 720p defaults.
    assign load_in  = cfg_legal && (!rst_n || !run_reg || frame_end);
    assign load_def = !rst_n && !cfg_legal;

    // Shadow configuration registers.
    always_ff @(posedge pixel_clk) begin
        if (load_in) begin
            h_total_s_reg  <= h_total;
            h_sync_s_reg   <= h_sync;
            h_bp_s_reg     <= h_bp;
            h_active_s_reg <= h_active;
            v_total_s_reg  <= v_total;
            v_sync_s_reg   <= v_sync;
            v_bp_s_reg     <= v_bp;
            v_active_s_reg <= v_active;
        end else if (load_def) begin
            h_total_s_reg  <= CNT_W'(DEF_H_TOTAL);
            h_sync_s_reg   <= CNT_W'(DEF_H_SYNC);
            h_bp_s_reg     <= CNT_W'(DEF_H_BP);
            h_active_s_reg <= CNT_W'(DEF_H_ACTIVE);
            v_total_s_reg  <= CNT_W'(DEF_V_TOTAL);
            v_sync_s_reg   <= CNT_W'(DEF_V_SYNC);
            v_bp_s_reg     <= CNT_W'(DEF_V_BP);
            v_active_s_reg <= CNT_W'(DEF_V_ACTIVE);
        end
    end

    // h/v counters. run_reg holds the counters at 0,0 across the release
    // edge so the first cycle out of reset is pixel 0 of line 0.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
            run_reg   <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (run_reg) begin
                if (h_last) begin
                    h_cnt_reg <= '0;
                    if (v_last) v_cnt_reg <= '0;
                    else        v_cnt_reg <= v_cnt_reg + CNT_W'(1);
                end else begin
                    h_cnt_reg <= h_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // Region decode: sync, back porch, active, front porch on each axis.
    always_comb begin
        h_act_start  = SW'(h_sync_s_reg) + SW'(h_bp_s_reg);
        h_act_end    = h_act_start + SW'(h_active_s_reg);
        v_act_start  = SW'(v_sync_s_reg) + SW'(v_bp_s_reg);
        v_act_end    = v_act_start + SW'(v_active_s_reg);
        h_act        = (SW'(h_cnt_reg) >= h_act_start) && (SW'(h_cnt_reg) < h_act_end);
        v_act        = (SW'(v_cnt_reg) >= v_act_start) && (SW'(v_cnt_reg) < v_act_end);
        hs_raw       = run_reg && (h_cnt_reg < h_sync_s_reg);
        vs_raw       = run_reg && (v_cnt_reg < v_sync_s_reg);
        pixel_rd_req = run_reg && h_act && v_act;
    end

    assign clr = !rst_n;

    always_comb begin
        sync_raw          = '0;
        sync_raw[SYNC_HS] = hs_raw;
        sync_raw[SYNC_VS] = vs_raw;
        sync_raw[SYNC_DE] = pixel_rd_req;
    end

    vout_tg_delay #(
        .DEPTH (DATA_LATENCY),
        .W     (SYNC_W)
    ) u_sync_dly (
        .pixel_clk (pixel_clk),
        .clr       (clr),
        .din       (sync_raw),
        .dout      (sync_dly),
        .tap       (sync_tap)
    );

    assign hs_o = sync_dly[SYNC_HS] ^ ~hs_pol;
    assign vs_o = sync_dly[SYNC_VS] ^ ~vs_pol;
    assign de_o = sync_dly[SYNC_DE];

`ifdef VOUT_TG_PATTERN_EN
    logic [CNT_W-1:0] act_x;
    logic [CNT_W+2:0] bar_quot;
    logic [2:0]       bar_idx, bar_dly, bar_tap;

    // Bar index = active x * 8 / h_active, computed on the undelayed counters.
    always_comb begin
        act_x    = h_cnt_reg - h_act_start[CNT_W-1:0];
        bar_quot = {act_x, 3'b000} / {3'b000, h_active_s_reg};
        bar_idx  = pixel_rd_req ? bar_quot[2:0] : 3'd0;
    end

    vout_tg_delay #(
        .DEPTH (DATA_LATENCY),
        .W     (3)
    ) u_bar_dly (
        .pixel_clk (pixel_clk),
        .clr       (clr),
        .din       (bar_idx),
        .dout      (bar_dly),
        .tap       (bar_tap)
    );

    // Pixel source: colour bars or upstream data, blanked outside active.
    always_comb begin
        pixel_next = BLANK_YCBCR;
        if (sync_tap[SYNC_DE]) begin
            pixel_next = pattern_sel ? bar_ycbcr(bar_tap) : pixel_ycbcr_i;
        end
    end
`else
    // Pixel source: upstream data, blanked outside active.
    always_comb begin
        pixel_next = BLANK_YCBCR;
        if (sync_tap[SYNC_DE]) pixel_next = pixel_ycbcr_i;
    end
`endif

    // Output pixel register, loaded on the same edge as the final de stage.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) pixel_ycbcr_o <= BLANK_YCBCR;
        else        pixel_ycbcr_o <= pixel_next;
    end

endmodule
